rans_ctrl: RTL and testbench

RANS_CTRL -- requirements
Module: rans_ctrl

---
 rtl/rans_pkg.sv | 19 +
 rtl/rans_byte_fifo.sv | 71 +++++++
 rtl/rans_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rans_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rans_pkg.sv
// rtl/rans_pkg.sv - shared FSM encoding and timing constants for the rANS controller
package rans_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RESTART,
        RUN,
        DRAIN,
        ERR
    } rans_state_t;

    // Encoder pipeline depth in cycles from symbol accept to byte output.
    localparam int ENC_LATENCY = 3;
    // FIFO slots kept free while streaming so in-flight encoder bytes always fit.
    localparam int FIFO_HEADROOM = 8;

endpackage

// File: rtl/rans_byte_fifo.sv
// rtl/rans_byte_fifo.sv - byte FIFO with two ordered write lanes and one read port
module rans_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en0,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic             wr_en1,
    input  logic [WIDTH-1:0] wr_data1,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_b;
    logic [CW-1:0]    space;
    logic [CW-1:0]    n_req;
    logic [CW-1:0]    n_acc;
    logic             do_rd;
    logic             ok0;
    logic             ok1;

    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];
    assign do_rd   = rd_en && !empty;

    // A slot freed by this cycle's read may be reused by this cycle's write.
    assign space    = CW'(DEPTH) - count + CW'(do_rd);
    assign ok0      = wr_en0 && (space != '0);
    assign ok1      = wr_en1 && (space > CW'(ok0));
    assign n_req    = CW'(wr_en0) + CW'(wr_en1);
    assign n_acc    = CW'(ok0) + CW'(ok1);
    assign wr_ptr_b = wr_ptr + AW'(ok0);

    always_ff @(posedge clk) begin
        if (ok0) begin
            mem[wr_ptr] <= wr_data0;
        end
        if (ok1) begin
            mem[wr_ptr_b] <= wr_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_acc);
            rd_ptr <= rd_ptr + AW'(do_rd);
            count  <= count + n_acc - CW'(do_rd);
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(rd_en && empty));
            assert (n_req <= space);
        end
    end

endmodule

// File: rtl/rans_ctrl.sv
// rtl/rans_ctrl.sv - rANS encoder controller: table load/check, symbol streaming, byte FIFO, drain
module rans_ctrl
    import rans_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [RESOLUTION-1:0]     cfg_freq_i,
    input  logic                      sym_valid_i,
    output logic                      sym_ready_o,
    input  logic [SYMBOL_WIDTH-1:0]   sym_i,
    input  logic                      sym_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SYMBOL_WIDTH-1:0]   out_data_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      enc_valid_o,
    output logic                      enc_freq_wr_o,
    output logic                      enc_restart_o,
    output logic [SYMBOL_WIDTH-1:0]   enc_freq_addr_o,
    output logic [SYMBOL_WIDTH-1:0]   enc_symb_o,
    output logic [RESOLUTION-1:0]     enc_freq_o,
    output logic [RESOLUTION-1:0]     enc_cum_freq_o,
    input  logic [1:0]                enc_valid_i,
    input  logic [2*SYMBOL_WIDTH-1:0] enc_data_i
);

    localparam int CUMW = RESOLUTION + SYMBOL_WIDTH + 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int DW   = $clog2(ENC_LATENCY + 1);
    localparam logic [CUMW-1:0] TOTAL = CUMW'(1) << RESOLUTION;

    rans_state_t              state;
    rans_state_t              state_nxt;
    logic [SYMBOL_WIDTH-1:0]  idx;
    logic [CUMW-1:0]          cum;
    logic                     table_ok;
    logic [DW-1:0]            drain_cnt;
    logic [DW-1:0]            disc_cnt;
    logic                     drain_done;
    logic                     cap_en;
    logic                     cap_push0;
    logic                     cap_push1;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;

    assign enc_freq_addr_o = idx;
    assign enc_freq_o      = cfg_freq_i;
    assign enc_cum_freq_o  = cum[RESOLUTION-1:0];
    assign enc_symb_o      = sym_i;

    // Bytes still emerging from the encoder pipeline after a reset belong to
    // the aborted frame and are dropped.
    assign cap_en    = !rst_i && (disc_cnt == '0);
    assign cap_push0 = cap_en && enc_valid_i[0];
    assign cap_push1 = cap_en && (enc_valid_i == 2'b11);

    always_comb begin
        state_nxt     = state;
        cfg_ready_o   = 1'b0;
        sym_ready_o   = 1'b0;
        enc_freq_wr_o = 1'b0;
        enc_valid_o   = 1'b0;
        enc_restart_o = 1'b0;
        drain_done    = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        state_nxt = LOAD;
                    end else if (sym_valid_i && table_ok) begin
                        state_nxt = RESTART;
                    end
                end
                LOAD: begin
                    cfg_ready_o   = 1'b1;
                    enc_freq_wr_o = cfg_valid_i;
                    if (cfg_valid_i && (idx == '1)) begin
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    state_nxt = (cum == TOTAL) ? IDLE : ERR;
                end
                RESTART: begin
                    enc_restart_o = 1'b1;
                    state_nxt     = RUN;
                end
                RUN: begin
                    sym_ready_o = (fifo_count <= CW'(FIFO_DEPTH - FIFO_HEADROOM));
                    enc_valid_o = sym_valid_i && sym_ready_o;
                    if (enc_valid_o && sym_last_i) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if ((drain_cnt == DW'(ENC_LATENCY)) && fifo_empty && !cap_push0) begin
                        drain_done = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                ERR: begin
                    state_nxt = ERR;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            idx       <= '0;
            cum       <= '0;
            table_ok  <= 1'b0;
            err_o     <= 1'b0;
            done_o    <= 1'b0;
            drain_cnt <= '0;
            disc_cnt  <= DW'(ENC_LATENCY);
        end else begin
            state  <= state_nxt;
            done_o <= drain_done;
            if (disc_cnt != '0) begin
                disc_cnt <= disc_cnt - 1'b1;
            end
            if (state == IDLE) begin
                idx <= '0;
                cum <= '0;
            end
            if (enc_freq_wr_o) begin
                idx <= idx + 1'b1;
                cum <= cum + CUMW'(cfg_freq_i);
            end
            // A table is only trusted once a complete load has summed correctly.
            if (state == LOAD) begin
                table_ok <= 1'b0;
            end
            if (state == CHECK) begin
                table_ok <= (cum == TOTAL);
                if (cum != TOTAL) begin
                    err_o <= 1'b1;
                end
            end
            if (state == DRAIN) begin
                if (drain_cnt != DW'(ENC_LATENCY)) begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (enc_valid_i != 2'b10);
        end
    end

    rans_byte_fifo #(
        .WIDTH (SYMBOL_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .wr_en0   (cap_push0),
        .wr_data0 (enc_data_i[SYMBOL_WIDTH-1:0]),
        .wr_en1   (cap_push1),
        .wr_data1 (enc_data_i[2*SYMBOL_WIDTH-1:SYMBOL_WIDTH]),
        .rd_en    (out_valid_o && out_ready_i),
        .rd_data  (out_data_o),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign out_valid_o = !fifo_empty;

endmodule

// File: tb/tb_rans_ctrl.sv
// tb/tb_rans_ctrl.sv - directed self-checking bench for rans_ctrl with a 3-stage encoder model
module tb_rans_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [9:0]  cfg_freq_i;
    logic        sym_valid_i;
    logic        sym_ready_o;
    logic [7:0]  sym_i;
    logic        sym_last_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic        done_o;
    logic        err_o;
    logic        enc_valid_o;
    logic        enc_freq_wr_o;
    logic        enc_restart_o;
    logic [7:0]  enc_freq_addr_o;
    logic [7:0]  enc_symb_o;
    logic [9:0]  enc_freq_o;
    logic [9:0]  enc_cum_freq_o;
    logic [1:0]  enc_valid_i;
    logic [15:0] enc_data_i;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q [$];
    logic [7:0]  popped [$];
    logic [1:0]  pv [3];
    logic [15:0] pd [3];
    int          disc;
    logic        sb_on;
    int          n_acc;
    logic [7:0]  frame [10] = '{8'h10, 8'hCD, 8'h22, 8'h35, 8'h40,
                                8'h01, 8'h5A, 8'h7F, 8'h88, 8'h93};

    rans_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_freq_i      (cfg_freq_i),
        .sym_valid_i     (sym_valid_i),
        .sym_ready_o     (sym_ready_o),
        .sym_i           (sym_i),
        .sym_last_i      (sym_last_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .enc_valid_o     (enc_valid_o),
        .enc_freq_wr_o   (enc_freq_wr_o),
        .enc_restart_o   (enc_restart_o),
        .enc_freq_addr_o (enc_freq_addr_o),
        .enc_symb_o      (enc_symb_o),
        .enc_freq_o      (enc_freq_o),
        .enc_cum_freq_o  (enc_cum_freq_o),
        .enc_valid_i     (enc_valid_i),
        .enc_data_i      (enc_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Encoder model: odd symbols emit two bytes {sym^66, sym}, even symbols one byte.
    task automatic tick();
        logic       acc;
        logic [7:0] asym;
        logic       discard;
        logic       was_rst;
        #2;
        acc     = enc_valid_o;
        asym    = enc_symb_o;
        discard = rst_i || (disc != 0);
        was_rst = rst_i;
        if (sb_on) begin
            chk("out_valid", out_valid_o, q.size() != 0);
            if (out_valid_o && out_ready_i && q.size() != 0) begin
                popped.push_back(out_data_o);
                chk("pop_data", out_data_o, q.pop_front());
            end
            if (!discard) begin
                if (enc_valid_i[0]) q.push_back(enc_data_i[7:0]);
                if (enc_valid_i == 2'b11) q.push_back(enc_data_i[15:8]);
            end
        end
        if (sym_valid_i && sym_ready_o) n_acc++;
        @(posedge clk_i);
        #1;
        if (was_rst) begin
            q.delete();
            disc = 3;
        end else if (disc != 0) begin
            disc--;
        end
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        if (acc) begin
            pv[0] = asym[0] ? 2'b11 : 2'b01;
            pd[0] = {asym ^ 8'h66, asym};
        end else begin
            pv[0] = 2'b00;
            pd[0] = 16'h0000;
        end
        enc_valid_i = pv[2];
        enc_data_i  = pd[2];
    endtask

    initial begin
        int done_seen;
        int done_at;
        int level_at_fall;

        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_freq_i = '0; sym_valid_i = 1'b0;
        sym_i = '0; sym_last_i = 1'b0; out_ready_i = 1'b0;
        enc_valid_i = 2'b00; enc_data_i = 16'h0000;
        for (int i = 0; i < 3; i++) begin pv[i] = 2'b00; pd[i] = 16'h0000; end
        disc = 3; sb_on = 1'b0; n_acc = 0;

        tick(); tick();
        chk("rst_cfg_ready", cfg_ready_o, 1'b0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_enc_valid", enc_valid_o, 1'b0);
        chk("rst_enc_freq_wr", enc_freq_wr_o, 1'b0);
        chk("rst_enc_restart", enc_restart_o, 1'b0);

        rst_i = 1'b0; sb_on = 1'b1; sym_valid_i = 1'b1;
        tick(); tick();
        chk("no_table_sym_ready", sym_ready_o, 1'b0);
        chk("no_table_restart", enc_restart_o, 1'b0);
        sym_valid_i = 1'b0;

        // Good table: freq 4 everywhere, total 1024.
        cfg_valid_i = 1'b1; cfg_freq_i = 10'd4;
        #1 chk("idle_cfg_ready", cfg_ready_o, 1'b0);
        tick();
        for (int i = 0; i < 256; i++) begin
            #1;
            chk("load_ready", cfg_ready_o, 1'b1);
            chk("load_wr", enc_freq_wr_o, 1'b1);
            chk("load_addr", enc_freq_addr_o, i);
            chk("load_freq", enc_freq_o, 10'd4);
            chk("load_cum", enc_cum_freq_o, 4 * i);
            tick();
        end
        cfg_valid_i = 1'b0;
        #1;
        chk("check_cfg_ready", cfg_ready_o, 1'b0);
        chk("check_wr", enc_freq_wr_o, 1'b0);
        tick();
        chk("good_err", err_o, 1'b0);
        chk("good_idle_cfg_ready", cfg_ready_o, 1'b0);

        // Ten-symbol frame.
        out_ready_i = 1'b1; sym_valid_i = 1'b1; sym_i = frame[0]; sym_last_i = 1'b0;
        popped.delete();
        tick();
        chk("restart_pulse", enc_restart_o, 1'b1);
        chk("restart_sym_ready", sym_ready_o, 1'b0);
        chk("restart_enc_valid", enc_valid_o, 1'b0);
        tick();
        chk("run_restart_low", enc_restart_o, 1'b0);
        for (int i = 0; i < 10; i++) begin
            sym_i = frame[i]; sym_last_i = (i == 9);
            #1;
            chk("run_sym_ready", sym_ready_o, 1'b1);
            chk("run_enc_valid", enc_valid_o, 1'b1);
            chk("run_enc_symb", enc_symb_o, frame[i]);
            tick();
        end
        sym_valid_i = 1'b0; sym_last_i = 1'b0;
        done_seen = 0; done_at = 0;
        for (int k = 1; k <= 30; k++) begin
            #1;
            if (k == 1) chk("drain_sym_ready", sym_ready_o, 1'b0);
            if (done_o) begin
                if (done_seen == 0) done_at = k;
                done_seen++;
                chk("done_fifo_empty", q.size(), 0);
                chk("done_out_valid", out_valid_o, 1'b0);
            end
            tick();
        end
        chk("done_count", done_seen, 1);
        chk("done_latency", done_at >= 4, 1'b1);
        chk("popped_count", popped.size(), 15);
        if (popped.size() >= 3) begin
            chk("byte_lo_first", popped[1], 8'hCD);
            chk("byte_hi_second", popped[2], 8'hAB);
        end

        // Back-pressure: one byte per symbol, output stalled.
        out_ready_i = 1'b0; sym_valid_i = 1'b1; sym_i = 8'h02; n_acc = 0;
        level_at_fall = -1;
        tick(); tick();
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("fill_sym_ready", sym_ready_o, q.size() <= 8);
            if (!sym_ready_o && level_at_fall < 0) level_at_fall = q.size();
            tick();
        end
        chk("fill_accepted", n_acc, 12);
        chk("fill_level_at_fall", level_at_fall, 9);
        chk("fill_out_data", out_data_o, 8'h02);

        // Drain while streaming, then reset with encoder bytes in flight.
        out_ready_i = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        rst_i = 1'b1; sym_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        #1;
        chk("run_rst_out_valid", out_valid_o, 1'b0);
        chk("run_rst_sym_ready", sym_ready_o, 1'b0);
        chk("run_rst_done", done_o, 1'b0);
        sym_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_restart", enc_restart_o, 1'b0);
        end
        chk("post_rst_out_valid", out_valid_o, 1'b0);
        sym_valid_i = 1'b0;

        // Reset in the middle of a table load.
        cfg_valid_i = 1'b1; cfg_freq_i = 10'd4;
        tick();
        for (int i = 0; i < 100; i++) tick();
        #1 chk("load100_addr", enc_freq_addr_o, 8'd100);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; cfg_valid_i = 1'b0;
        #1;
        chk("partial_err", err_o, 1'b0);
        chk("partial_cfg_ready", cfg_ready_o, 1'b0);
        chk("partial_wr", enc_freq_wr_o, 1'b0);
        sym_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("partial_no_restart", enc_restart_o, 1'b0);
            chk("partial_sym_ready", sym_ready_o, 1'b0);
            chk("partial_enc_valid", enc_valid_o, 1'b0);
        end
        sym_valid_i = 1'b0;

        // Bad table: symbol 0 has freq 5, total 1025.
        cfg_valid_i = 1'b1; cfg_freq_i = 10'd5;
        tick();
        for (int i = 0; i < 256; i++) begin
            cfg_freq_i = (i == 0) ? 10'd5 : 10'd4;
            #1;
            if (i == 1) chk("bad_cum1", enc_cum_freq_o, 10'd5);
            if (i == 255) chk("bad_cum255", enc_cum_freq_o, 10'd1021);
            tick();
        end
        sym_valid_i = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("err_flag", err_o, 1'b1);
            chk("err_cfg_ready", cfg_ready_o, 1'b0);
            chk("err_sym_ready", sym_ready_o, 1'b0);
            chk("err_wr", enc_freq_wr_o, 1'b0);
            chk("err_restart", enc_restart_o, 1'b0);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; cfg_valid_i = 1'b0; sym_valid_i = 1'b0;
        #1 chk("err_cleared", err_o, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
